lfsr_seq_ctrl: RTL

LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

---
 rtl/lfsr_seq_pkg.sv | 34 +++
 rtl/lfsr_seq_cnt.sv | 30 +++
 rtl/lfsr_seq_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/lfsr_seq_pkg.sv
// Shared types and constants for the LFSR sequencing controller.
// Holds the FSM state encoding, the LFSR mode pin codes and the pin bundle
// the controller decodes from its state.
package lfsr_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREP    = 3'd1,
        ST_TAP_LO  = 3'd2,
        ST_TAP_HI  = 3'd3,
        ST_SEED_LO = 3'd4,
        ST_SEED_HI = 3'd5,
        ST_RUN     = 3'd6,
        ST_FIN     = 3'd7
    } state_t;

    localparam logic [1:0] MODE_SHIFT = 2'd0;
    localparam logic [1:0] MODE_REG   = 2'd1;
    localparam logic [1:0] MODE_TAPS  = 2'd2;
    localparam logic [1:0] MODE_HOLD  = 2'd3;

    // Everything the controller drives onto the LFSR in one cycle.
    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] data;
        logic       rst;
    } lfsr_pins_t;

    // Select the low or high nibble of a byte.
    function automatic logic [3:0] nib(input logic [7:0] b, input logic hi);
        return hi ? b[7:4] : b[3:0];
    endfunction

endpackage

// File: rtl/lfsr_seq_cnt.sv
// Loadable step down-counter for the RUN phase.
// 'zero' marks an empty run (skip RUN), 'last' marks the final RUN cycle.
module lfsr_seq_cnt #(
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [STEP_W-1:0] load_val,
    input  logic              dec,
    output logic              zero,
    output logic              last
);

    logic [STEP_W-1:0] cnt;

    // Load wins over decrement; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - STEP_W'(1);
    end

    assign zero = (cnt == '0);
    assign last = (cnt == STEP_W'(1));

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// LFSR sequencing controller: programs taps and seed into an external
// nibble-loaded LFSR, shifts it a requested number of steps, then captures
// the register value into 'result' with a one-cycle 'done' pulse.
// Optional feature: define LFSR_SEQ_CLEAR_EN to pulse lfsr_rst during PREP
// (with the LFSR held) instead of a dummy shift; cycle timing is identical.
module lfsr_seq_ctrl
    import lfsr_seq_pkg::*;
#(
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        seed_i,
    input  logic [7:0]        taps_i,
    input  logic [STEP_W-1:0] steps_i,
    input  logic [7:0]        lfsr_q,
    output logic [1:0]        lfsr_mode,
    output logic [3:0]        lfsr_data,
    output logic              lfsr_rst,
    output logic              busy,
    output logic              done,
    output logic [7:0]        result
);

    state_t     state, state_nxt;
    logic [7:0] seed_r, taps_r;
    logic       accept;
    logic       cnt_zero, cnt_last;
    logic       finish;
    lfsr_pins_t pins;

    // Start is only honoured in IDLE, and abort overrides it.
    assign accept = (state == ST_IDLE) && start && !abort;
    // A clean pass through FIN is the only way to complete.
    assign finish = (state == ST_FIN) && !abort;

    // Step count lives in the counter; it is loaded on acceptance.
    lfsr_seq_cnt #(.STEP_W(STEP_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (steps_i),
        .dec      (state == ST_RUN),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Capture seed and taps when a request is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_r <= '0;
            taps_r <= '0;
        end else if (accept) begin
            seed_r <= seed_i;
            taps_r <= taps_i;
        end
    end

    // Next-state logic; abort returns to IDLE from any busy state.
    always_comb begin
        state_nxt = state;
        if ((state != ST_IDLE) && abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (accept) state_nxt = ST_PREP;
                ST_PREP:    state_nxt = ST_TAP_LO;
                ST_TAP_LO:  state_nxt = ST_TAP_HI;
                ST_TAP_HI:  state_nxt = ST_SEED_LO;
                ST_SEED_LO: state_nxt = ST_SEED_HI;
                ST_SEED_HI: state_nxt = cnt_zero ? ST_FIN : ST_RUN;
                ST_RUN:     state_nxt = cnt_last ? ST_FIN : ST_RUN;
                ST_FIN:     state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    // Moore decode of the LFSR pins from the current state.
    always_comb begin
        pins.mode = MODE_HOLD;
        pins.data = 4'h0;
        pins.rst  = 1'b0;
        case (state)
            ST_PREP: begin
`ifdef LFSR_SEQ_CLEAR_EN
                pins.mode = MODE_HOLD;
                pins.rst  = 1'b1;
`else
                // A shift clears the LFSR's nibble toggle before loading.
                pins.mode = MODE_SHIFT;
`endif
            end
            ST_TAP_LO: begin
                pins.mode = MODE_TAPS;
                pins.data = nib(taps_r, 1'b0);
            end
            ST_TAP_HI: begin
                pins.mode = MODE_TAPS;
                pins.data = nib(taps_r, 1'b1);
            end
            ST_SEED_LO: begin
                pins.mode = MODE_REG;
                pins.data = nib(seed_r, 1'b0);
            end
            ST_SEED_HI: begin
                pins.mode = MODE_REG;
                pins.data = nib(seed_r, 1'b1);
            end
            ST_RUN:  pins.mode = MODE_SHIFT;
            default: pins.mode = MODE_HOLD;
        endcase
    end

    assign lfsr_mode = pins.mode;
    assign lfsr_data = pins.data;
    assign lfsr_rst  = pins.rst;
    assign busy      = (state != ST_IDLE);

    // Completion: sample the LFSR on the FIN exit edge, pulse done once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= finish;
            if (finish)
                result <= lfsr_q;
        end
    end

endmodule
